// File: rtl/reg_port_arb.sv
// reg_port_arb: round-robin arbiter that shares one register-file port
// between NUM_REQ requesters. A requester may lock the port to run a
// read-modify-write sequence without interleaving from the others.
//
// Handshake: requester i transfers in a cycle where req[i] && gnt[i].
// gnt is combinational, so it can be consumed in the same cycle. A requester
// that is not granted must hold req/req_wr/req_lock/req_addr/req_wdata stable
// until it is granted. The accepted transfer appears on the rf_* port one
// cycle later. Reads return rsp_valid/rsp_id/rsp_data two cycles after
// acceptance. There is no backpressure on the response.
module reg_port_arb #(
  parameter int NUM_REQ  = 3,
  parameter int NUM_REGS = 128,
  localparam int RADDR_WD = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int ID_WD    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_wr,
  input  logic [NUM_REQ-1:0]          req_lock,
  input  logic [NUM_REQ*RADDR_WD-1:0] req_addr,
  input  logic [NUM_REQ*128-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]          gnt,
  output logic                        rsp_valid,
  output logic [ID_WD-1:0]            rsp_id,
  output logic [127:0]                rsp_data,
  output logic [RADDR_WD-1:0]         rf_addr,
  output logic                        rf_wr,
  output logic [127:0]                rf_wdata,
  input  logic [127:0]                rf_rdata,
  output logic                        dbg_locked,
  output logic [ID_WD-1:0]            dbg_ptr,
  output logic [ID_WD-1:0]            dbg_owner
);

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t              state;
  logic [ID_WD-1:0]    ptr;
  logic [ID_WD-1:0]    owner;

  logic                gnt_any;
  logic [ID_WD-1:0]    gnt_idx;
  logic [ID_WD-1:0]    ptr_inc;
  logic [RADDR_WD-1:0] sel_addr;
  logic [127:0]        sel_wdata;

  // read pipeline stage between acceptance and response
  logic                rd_v1;
  logic [ID_WD-1:0]    rd_id1;

  // Grant selection: owner only while locked, else first request at or after ptr.
  always_comb begin
    int idx;
    logic [ID_WD-1:0] cand;
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    cand    = '0;
    if (!reset) begin
      gnt_any = 1'b0;
    end else if (state == LOCKED) begin
      if (req[owner]) begin
        gnt_any = 1'b1;
        gnt_idx = owner;
      end
    end else begin
      // Walk from lowest priority to highest so the highest-priority hit wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        idx = int'(ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        cand = ID_WD'(idx);
        if (req[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  // Pointer successor of the granted index, with wrap to 0.
  always_comb begin
    if (gnt_idx == ID_WD'(NUM_REQ - 1)) ptr_inc = '0;
    else                                ptr_inc = gnt_idx + 1'b1;
  end

  // Winner's address and write data, taken from its packed slices.
  always_comb begin
    sel_addr  = req_addr[gnt_idx*RADDR_WD +: RADDR_WD];
    sel_wdata = req_wdata[gnt_idx*128 +: 128];
  end

  // Arbitration FSM: pointer, lock state and lock owner.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ARB;
      ptr   <= '0;
      owner <= '0;
    end else if (gnt_any) begin
      if (state == ARB) begin
        ptr <= ptr_inc;
        if (req_lock[gnt_idx]) begin
          state <= LOCKED;
          owner <= gnt_idx;
        end
      end else if (!req_lock[gnt_idx]) begin
        // Owner's final transfer of the locked sequence still executes.
        state <= ARB;
        ptr   <= ptr_inc;
      end
    end
  end

  // Register-file port and read-response pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_addr   <= '0;
      rf_wr     <= 1'b0;
      rf_wdata  <= '0;
      rd_v1     <= 1'b0;
      rd_id1    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
    end else begin
      rf_wr <= gnt_any & req_wr[gnt_idx];
      if (gnt_any) begin
        rf_addr  <= sel_addr;
        rf_wdata <= sel_wdata;
      end
      rd_v1     <= gnt_any & ~req_wr[gnt_idx];
      rd_id1    <= gnt_idx;
      rsp_valid <= rd_v1;
      rsp_id    <= rd_id1;
    end
  end

  // Register file returns data in the cycle rsp_valid is high.
  assign rsp_data   = rsp_valid ? rf_rdata : '0;

  assign dbg_locked = (state == LOCKED);
  assign dbg_ptr    = ptr;
  assign dbg_owner  = owner;

endmodule
